// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: 8-deep first-word-fall-through FIFO built on the
// single-port synchronous RAM ram_single (one port, 1-cycle read).
//
// Ports
//   clk, rst        : clock (rising edge), async active-high reset
//   wr_valid/ready  : producer handshake, wr_data is the word
//   rd_valid/ready  : consumer handshake, rd_data is the head word
//   count           : words held in RAM (output register excluded)
//   full, empty     : count==depth / nothing stored anywhere
//   err             : sticky write-while-full flag
//   addm,cs_n,we_n  : RAM address and active-low controls
//   din, ram_dout   : RAM write data / RAM read data
//
// Build option: define RAM_FIFO_ERR_EN to build the err flag;
// otherwise err is tied low.

module ram_fifo_ctrl #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_valid,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   input  logic              rd_ready,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              empty,
   output logic              err,
   output logic [ADDR_W-1:0] addm,
   output logic              cs_n,
   output logic              we_n,
   output logic [DATA_W-1:0] din,
   input  logic [DATA_W-1:0] ram_dout
);

   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_FETCH = 1'b1
   } state_t;

   state_t              state_q;
   state_t              state_d;

   logic [ADDR_W-1:0]   wr_ptr_q;
   logic [ADDR_W-1:0]   wr_ptr_d;
   logic [ADDR_W-1:0]   rd_ptr_q;
   logic [ADDR_W-1:0]   rd_ptr_d;
   logic [ADDR_W:0]     count_q;
   logic [ADDR_W:0]     count_d;
   logic                rd_valid_q;
   logic                rd_valid_d;
   logic [DATA_W-1:0]   rd_data_q;
   logic [DATA_W-1:0]   rd_data_d;
   logic [ADDR_W-1:0]   addm_q;
   logic [ADDR_W-1:0]   addm_d;
   logic [DATA_W-1:0]   din_q;
   logic [DATA_W-1:0]   din_d;

   logic                fetch_go;
   logic                wr_go;

   // A prefetch may start only when the output register is free or
   // being emptied this cycle; it always wins the RAM port.
   assign fetch_go = !rst
                     && (state_q == S_IDLE)
                     && (count_q != '0)
                     && (!rd_valid_q || rd_ready);

   assign wr_ready = !rst
                     && (count_q != DEPTH)
                     && !fetch_go;

   assign wr_go = wr_valid && wr_ready;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (fetch_go) begin
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ---------------- FSM: outputs / RAM port ----------------
   // The port is idle unless a fetch or write is issued; address
   // and write data then keep whatever was last driven.
   always_comb begin
      cs_n   = 1'b1;
      we_n   = 1'b1;
      addm_d = addm_q;
      din_d  = din_q;
      if (fetch_go) begin
         cs_n   = 1'b0;
         addm_d = rd_ptr_q;
      end else if (wr_go) begin
         cs_n   = 1'b0;
         we_n   = 1'b0;
         addm_d = wr_ptr_q;
         din_d  = wr_data;
      end
   end

   assign addm = addm_d;
   assign din  = din_d;

   // ---------------- pointers and occupancy ----------------
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_go) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
         count_d  = count_q + 1'b1;
      end else if (fetch_go) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         count_d  = count_q - 1'b1;
      end
   end

   // ---------------- output register ----------------
   // The RAM word is valid during FETCH; a load beats a consume.
   always_comb begin
      rd_valid_d = rd_valid_q;
      rd_data_d  = rd_data_q;
      if (state_q == S_FETCH) begin
         rd_valid_d = 1'b1;
         rd_data_d  = ram_dout;
      end else if (rd_valid_q && rd_ready) begin
         rd_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         addm_q     <= '0;
         din_q      <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         addm_q     <= addm_d;
         din_q      <= din_d;
      end
   end

   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;
   assign count    = count_q;
   assign full     = (count_q == DEPTH);

   // A word in flight during FETCH still counts as stored.
   assign empty = (count_q == '0)
                  && (state_q != S_FETCH)
                  && !rd_valid_q;

   // ---------------- error flag ----------------
`ifdef RAM_FIFO_ERR_EN
   logic err_q;
   logic err_d;

   assign err_d = err_q || (wr_valid && full);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: bench for ram_fifo_ctrl with a behavioural
// single-port RAM, cycle vectors and a data scoreboard.

module tb_ram_fifo_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_valid = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       wr_ready;
   logic       rd_valid;
   logic [7:0] rd_data;
   logic       rd_ready = 1'b0;
   logic [3:0] count;
   logic       full;
   logic       empty;
   logic       err;
   logic [2:0] addm;
   logic       cs_n;
   logic       we_n;
   logic [7:0] din;
   logic [7:0] ram_dout;

   logic [7:0] mem [8];

`ifdef RAM_FIFO_ERR_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   int ntests = 0;
   int nfail  = 0;
   int ncons  = 0;

   logic [7:0] sb [$];
   logic [2:0] wr_addrs [$];
   logic [2:0] rd_addrs [$];

   typedef struct {
      logic       wv;
      logic [7:0] wd;
      logic       rr;
      logic       wrdy;
      logic       rv;
      logic [7:0] rd;
      logic [3:0] cnt;
      logic       csn;
      logic       wen;
      logic [2:0] adr;
      logic       emp;
   } vec_t;

   localparam int NV = 13;
   vec_t vt [NV];

   ram_fifo_ctrl #(.DATA_W(8), .ADDR_W(3)) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_valid (wr_valid),
      .wr_data  (wr_data),
      .wr_ready (wr_ready),
      .rd_valid (rd_valid),
      .rd_data  (rd_data),
      .rd_ready (rd_ready),
      .count    (count),
      .full     (full),
      .empty    (empty),
      .err      (err),
      .addm     (addm),
      .cs_n     (cs_n),
      .we_n     (we_n),
      .din      (din),
      .ram_dout (ram_dout)
   );

   always #5 clk = ~clk;

   // ram_single behaviour: write or 1-cycle registered read
   always @(posedge clk) begin
      if (!cs_n) begin
         if (!we_n) mem[addm] <= din;
         else       ram_dout <= mem[addm];
      end
   end

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] expv);
      ntests++;
      if (act !== expv) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   task automatic setv(input int i,
                       input logic wv, input logic [7:0] wd,
                       input logic rr, input logic wrdy,
                       input logic rv, input logic [7:0] rd,
                       input logic [3:0] cnt, input logic csn,
                       input logic wen, input logic [2:0] adr,
                       input logic emp);
      vt[i].wv = wv;    vt[i].wd = wd;   vt[i].rr = rr;
      vt[i].wrdy = wrdy; vt[i].rv = rv;  vt[i].rd = rd;
      vt[i].cnt = cnt;  vt[i].csn = csn; vt[i].wen = wen;
      vt[i].adr = adr;  vt[i].emp = emp;
   endtask

   // Scoreboard monitor, sampled mid low phase.
   task automatic mon();
      logic [7:0] e;
      if (!rst) begin
         if (wr_valid && wr_ready) begin
            sb.push_back(wr_data);
            wr_addrs.push_back(addm);
         end
         if (!cs_n && we_n) rd_addrs.push_back(addm);
         if (rd_valid && rd_ready) begin
            ncons++;
            ntests++;
            if (sb.size() == 0) begin
               nfail++;
               $display("FAIL sb_underflow: got %0h expected none",
                        rd_data);
            end else begin
               e = sb.pop_front();
               if (rd_data !== e) begin
                  nfail++;
                  $display("FAIL sb_data: got %0h expected %0h",
                           rd_data, e);
               end
            end
         end
      end
   endtask

   task automatic write_word(input logic [7:0] d);
      int n = 0;
      @(negedge clk);
      wr_valid = 1'b1;
      wr_data  = d;
      #1;
      while (!wr_ready && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("wr_accept", 32'(wr_ready), 32'(1));
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
   endtask

   task automatic wait_empty();
      int n = 0;
      @(negedge clk);
      #1;
      while (!empty && n < 60) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("wait_empty", 32'(empty), 32'(1));
   endtask

   initial begin
      logic [19:0] act;
      logic [19:0] expv;
      logic [2:0]  ea [8];
      int          c0;
      int          n;

      fork
         forever begin
            @(negedge clk);
            #3;
            mon();
         end
      join_none

      //   wv wd      rr  wrdy rv rd     cnt  csn wen adr  emp
      setv(0, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0,
           1'b0, 1'b0, 3'd0, 1'b1);
      setv(1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 4'd1,
           1'b0, 1'b1, 3'd0, 1'b0);
      setv(2, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0,
           1'b1, 1'b1, 3'd0, 1'b0);
      setv(3, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h5A, 4'd0,
           1'b1, 1'b1, 3'd0, 1'b0);
      setv(4, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0,
           1'b1, 1'b1, 3'd0, 1'b1);
      setv(5, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0,
           1'b0, 1'b0, 3'd1, 1'b1);
      setv(6, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 8'h00, 4'd1,
           1'b0, 1'b1, 3'd1, 1'b0);
      setv(7, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0,
           1'b0, 1'b0, 3'd2, 1'b0);
      setv(8, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h11, 4'd1,
           1'b1, 1'b1, 3'd2, 1'b0);
      setv(9, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h11, 4'd1,
           1'b0, 1'b1, 3'd2, 1'b0);
      setv(10, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0,
           1'b1, 1'b1, 3'd2, 1'b0);
      setv(11, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 4'd0,
           1'b1, 1'b1, 3'd2, 1'b0);
      setv(12, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0,
           1'b1, 1'b1, 3'd2, 1'b1);

      // reset state
      @(negedge clk);
      #1;
      chk("rst_csn", 32'(cs_n), 32'(1));
      chk("rst_wen", 32'(we_n), 32'(1));
      chk("rst_wrdy", 32'(wr_ready), 32'(0));
      chk("rst_flags", 32'({full, empty, err, rd_valid}),
          32'(4'b0100));
      chk("rst_cnt", 32'(count), 32'(0));
      chk("rst_port", 32'({addm, din}), 32'(0));
      @(negedge clk);
      rst = 1'b0;

      // cycle vectors: single word, then back-to-back traffic
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         wr_valid = vt[i].wv;
         wr_data  = vt[i].wd;
         rd_ready = vt[i].rr;
         #1;
         act = {wr_ready, rd_valid, rd_valid ? rd_data : 8'h00,
                count, cs_n, we_n, addm, empty};
         expv = {vt[i].wrdy, vt[i].rv, vt[i].rd, vt[i].cnt,
                 vt[i].csn, vt[i].wen, vt[i].adr, vt[i].emp};
         chk($sformatf("vec%0d", i), 32'(act), 32'(expv));
      end

      // one more word moves both pointers to 4
      rd_ready = 1'b1;
      write_word(8'h33);
      wait_empty();
      rd_ready = 1'b0;

      // fill: 9 words, first lands in the output register
      for (int k = 1; k <= 9; k++) write_word(8'(k));
      rd_addrs.delete();
      @(negedge clk);
      #1;
      chk("fill_cnt", 32'(count), 32'(8));
      chk("fill_full", 32'(full), 32'(1));
      chk("fill_wrdy", 32'(wr_ready), 32'(0));
      chk("fill_head", 32'({rd_valid, rd_data}), 32'(9'h101));
      chk("fill_err0", 32'(err), 32'(0));

      // write while full
      @(negedge clk);
      wr_valid = 1'b1;
      wr_data  = 8'h0A;
      #1;
      chk("ovf_wrdy", 32'(wr_ready), 32'(0));
      @(negedge clk);
      wr_valid = 1'b0;
      #1;
      chk("ovf_err", 32'(err), 32'(EXP_ERR));
      chk("ovf_cnt", 32'(count), 32'(8));

      // drain with address wrap
      c0 = ncons;
      rd_ready = 1'b1;
      wait_empty();
      rd_ready = 1'b0;
      chk("drain_n", 32'(ncons - c0), 32'(9));
      chk("drain_cnt", 32'(count), 32'(0));
      chk("drain_sb", 32'(sb.size()), 32'(0));
      ea = '{3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
      chk("drain_nrd", 32'(rd_addrs.size()), 32'(8));
      for (int k = 0; k < 8 && k < rd_addrs.size(); k++)
         chk($sformatf("drain_addr%0d", k),
             32'(rd_addrs[k]), 32'(ea[k]));

      // refill, then contention
      for (int k = 0; k < 9; k++) write_word(8'h11 + 8'(k));
      @(negedge clk);
      wr_valid = 1'b1;
      wr_data  = 8'h1A;
      rd_ready = 1'b1;
      #1;
      chk("cont_c0", 32'({wr_ready, cs_n, we_n, count}),
          32'({3'b001, 4'd8}));
      @(negedge clk);
      rd_ready = 1'b0;
      #1;
      chk("cont_c1", 32'({wr_ready, cs_n, we_n, count}),
          32'({3'b100, 4'd7}));
      @(negedge clk);
      wr_valid = 1'b0;
      #1;
      chk("cont_c2", 32'({full, count}), 32'({1'b1, 4'd8}));

      // reset asserted mid-cycle while full
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("mrst", 32'({cs_n, we_n, wr_ready, rd_valid, empty,
                        full, err, count}),
          32'({7'b1100100, 4'd0}));
      sb.delete();
      @(negedge clk);
      rst = 1'b0;

      // reset during FETCH
      @(negedge clk);
      wr_valid = 1'b1;
      wr_data  = 8'h77;
      #1;
      chk("mf_acc", 32'(wr_ready), 32'(1));
      @(negedge clk);
      wr_valid = 1'b0;
      #1;
      chk("mf_fetch", 32'({cs_n, we_n}), 32'(2'b01));
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mf_rv", 32'(rd_valid), 32'(0));
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      wr_addrs.delete();
      repeat (3) begin
         @(negedge clk);
         #1;
         chk("mf_idle", 32'({rd_valid, empty}), 32'(2'b01));
      end

      // first write after reset goes to address 0
      rd_ready = 1'b1;
      write_word(8'hA5);
      n = 0;
      @(negedge clk);
      #1;
      while (!rd_valid && n < 10) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("a5_data", 32'({rd_valid, rd_data}), 32'(9'h1A5));
      chk("a5_nwr", 32'(wr_addrs.size()), 32'(1));
      if (wr_addrs.size() > 0)
         chk("a5_addr", 32'(wr_addrs[0]), 32'(0));
      repeat (2) @(negedge clk);
      #1;
      chk("end_sb", 32'(sb.size()), 32'(0));
      chk("end_empty", 32'(empty), 32'(1));

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
